bus_fifo_arb: RTL and testbench
===============================

BUS_FIFO_ARB -- requirements
Module: bus_fifo_arb

Interface
REQ-001 Parameter NSRC, default 4, SHALL set the number of requesting sources (2..16).
REQ-002 Parameter W, default 32, SHALL set the data word width; only W=32 is supported.
REQ-003 clk_i  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 rst_i  input  1  SHALL be the reset: synchronous, active-high.
REQ-005 src_data_i  input  NSRC*32  SHALL carry the data words; source k occupies bits [32k+31:32k].
REQ-006 src_valid_i  input  NSRC  SHALL flag a valid word per source.
REQ-007 src_last_i  input  NSRC  SHALL mark the final word of a packet per source.
REQ-008 src_ready_o  output  NSRC  SHALL accept the word per source.
REQ-009 fifo_data_o  output  32  SHALL be the word written to the downstream bus FIFO.
REQ-010 fifo_we_o  output  1  SHALL be the FIFO write request.
REQ-011 fifo_full_i  input  1  SHALL be the downstream FIFO full flag; the FIFO has no overflow protection.
REQ-012 grant_o  output  NSRC  SHALL be the one-hot current owner, all-zero when idle.
REQ-013 busy_o  output  1  SHALL be high whenever the state is not IDLE.

Function
REQ-014 The FSM SHALL have states IDLE, DATA and TRAILER.
REQ-015 In IDLE with any src_valid_i set, the arbiter SHALL register a grant to the first valid source searched round-robin from (last_grant+1) mod NSRC, and SHALL enter DATA on the next cycle.
REQ-016 In IDLE, src_ready_o SHALL be 0 and fifo_we_o SHALL be 0.
REQ-017 In DATA, src_ready_o[g] SHALL equal !fifo_full_i for granted source g; all other bits SHALL be 0.
REQ-018 A transfer SHALL occur when src_valid_i[g] and src_ready_o[g] are both high.
REQ-019 On a transfer, fifo_we_o SHALL be 1 and fifo_data_o SHALL be the granted source's word in the same cycle (zero latency, combinational path).
REQ-020 fifo_we_o SHALL never be asserted while fifo_full_i is 1.
REQ-021 Each transfer SHALL increment a 16-bit word counter; when the counter wraps from 0xFFFF, a sticky overflow bit SHALL be set for the packet.
REQ-022 A transfer with src_last_i[g]=1 SHALL move the FSM to TRAILER.
REQ-023 In TRAILER with fifo_full_i=0, the block SHALL write the trailer word and return to IDLE.
REQ-024 The trailer word SHALL be [31:28]=4'hE, [27:24]=source id, [23:17]=0, [16]=overflow, [15:0]=count.
REQ-025 The trailer count SHALL include the last word and exclude the trailer.
REQ-026 The trailer write SHALL clear the counter and overflow bit and store last_grant=g.
REQ-027 In TRAILER with fifo_full_i=1, the block SHALL hold with no write.
REQ-028 Deassertion of src_valid_i mid-packet SHALL stall in DATA without releasing the grant; packets SHALL never interleave in the FIFO.
REQ-029 A new arbitration SHALL begin only in the cycle after the trailer write, so the minimum packet cycle is words+2 cycles.
REQ-030 Valid bits of non-granted sources SHALL be ignored until the FSM reaches IDLE.

Reset
REQ-031 While rst_i is high, the block SHALL enter IDLE with grant_o=0, busy_o=0, src_ready_o=0, fifo_we_o=0, fifo_data_o=0, counter=0 and overflow=0.
REQ-032 Reset SHALL set last_grant=NSRC-1 so that source 0 has first priority.
REQ-033 A reset asserted mid-packet SHALL abandon the packet with no trailer; the downstream FIFO is cleared by the same rst_i.

Structure
REQ-034 A shared package bus_arb_pkg SHALL hold the state enumeration, the trailer marker 4'hE and the trailer field positions.
REQ-035 The round-robin priority search SHALL be a sub-module rr_pick, combinational, with inputs req[NSRC] and last[log2 NSRC] and outputs gnt one-hot and any.

Verification
REQ-036 Source 1 sends 3 words 0x11,0x22,0x33 with last on 0x33, FIFO never full -> FIFO receives 0x11,0x22,0x33,0xE1000003; busy_o is high for 4 cycles.
REQ-037 Out of reset, all 4 sources hold 1-word packets continuously -> grant order is 0,1,2,3,0; each trailer carries id=k and count=1.
REQ-038 fifo_full_i is forced high for 5 cycles mid-packet and again during TRAILER -> no fifo_we_o while full; data order is preserved; the trailer is written after release.
REQ-039 Source 2 drops src_valid_i for 3 cycles mid-packet while source 0 is valid -> grant stays on source 2; source 0 data is not interleaved.
REQ-040 Source 0 sends a 65537-word packet -> trailer is 0xE0010001 (overflow=1, count=1).
REQ-041 rst_i is asserted 2 words into a packet -> the next cycle shows IDLE with all outputs 0; the next grant goes to source 0 if it is valid.

Source files
------------

// File: rtl/bus_arb_pkg.sv
// Shared types and trailer layout for the packet bus arbiter.
package bus_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DATA    = 2'd1,
    ST_TRAILER = 2'd2
  } state_t;

  localparam int unsigned CNT_W        = 16;
  localparam logic [3:0]  TRL_MARKER   = 4'hE;
  localparam int unsigned TRL_MARK_LSB = 28;
  localparam int unsigned TRL_ID_LSB   = 24;
  localparam int unsigned TRL_OVF_BIT  = 16;
  localparam int unsigned TRL_CNT_LSB  = 0;

  // Assemble the end-of-packet trailer word; bits [23:17] stay zero.
  function automatic logic [31:0] make_trailer(input logic [3:0]       id,
                                               input logic             ovf,
                                               input logic [CNT_W-1:0] cnt);
    logic [31:0] t;
    t = '0;
    t[TRL_MARK_LSB +: 4]    = TRL_MARKER;
    t[TRL_ID_LSB +: 4]      = id;
    t[TRL_OVF_BIT]          = ovf;
    t[TRL_CNT_LSB +: CNT_W] = cnt;
    return t;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request after 'last', wrapping.
module rr_pick #(
  parameter int unsigned NSRC = 4,
  parameter int unsigned LW   = 2
) (
  input  logic [NSRC-1:0] req,
  input  logic [LW-1:0]   last,
  output logic [NSRC-1:0] gnt,
  output logic            any
);

  logic [LW-1:0] idx;

  // Walk sources last+1 .. last+NSRC and take the first requester.
  always_comb begin
    gnt = '0;
    any = 1'b0;
    idx = '0;
    for (int unsigned i = 1; i <= NSRC; i++) begin
      idx = LW'((32'(last) + i) % NSRC);
      if (!any && req[idx]) begin
        gnt[idx] = 1'b1;
        any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_fifo_arb.sv
// Packet arbiter: grants one source at a time into a bus FIFO and appends a trailer.
module bus_fifo_arb
  import bus_arb_pkg::*;
#(
  parameter int unsigned NSRC = 4,
  parameter int unsigned W    = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NSRC*W-1:0] src_data_i,
  input  logic [NSRC-1:0]   src_valid_i,
  input  logic [NSRC-1:0]   src_last_i,
  output logic [NSRC-1:0]   src_ready_o,
  output logic [W-1:0]      fifo_data_o,
  output logic              fifo_we_o,
  input  logic              fifo_full_i,
  output logic [NSRC-1:0]   grant_o,
  output logic              busy_o
);

  localparam int unsigned LW = $clog2(NSRC);

  state_t            state;
  state_t            state_next;
  logic [LW-1:0]     gidx;
  logic [LW-1:0]     last_grant;
  logic [CNT_W-1:0]  cnt;
  logic              ovf;
  logic [NSRC-1:0]   pick_gnt;
  logic              pick_any;
  logic [LW-1:0]     pick_idx;
  logic              xfer;
  logic              trl_wr;
  logic [W-1:0]      words [NSRC];

  for (genvar k = 0; k < NSRC; k++) begin : g_word
    assign words[k] = src_data_i[k*W +: W];
  end

  rr_pick #(.NSRC(NSRC), .LW(LW)) u_pick (
    .req  (src_valid_i),
    .last (last_grant),
    .gnt  (pick_gnt),
    .any  (pick_any)
  );

  // One-hot pick to source index.
  always_comb begin
    pick_idx = '0;
    for (int unsigned i = 0; i < NSRC; i++) begin
      if (pick_gnt[i]) pick_idx = LW'(i);
    end
  end

  // FSM state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Next state and zero-latency bus outputs; everything forced low during reset.
  always_comb begin
    state_next  = state;
    src_ready_o = '0;
    fifo_we_o   = 1'b0;
    fifo_data_o = '0;
    grant_o     = '0;
    busy_o      = 1'b0;
    xfer        = 1'b0;
    trl_wr      = 1'b0;
    if (!rst_i) begin
      if (state != ST_IDLE) begin
        busy_o        = 1'b1;
        grant_o[gidx] = 1'b1;
      end
      case (state)
        ST_IDLE: begin
          if (pick_any) state_next = ST_DATA;
        end
        ST_DATA: begin
          src_ready_o[gidx] = !fifo_full_i;
          if (src_valid_i[gidx] && !fifo_full_i) begin
            xfer        = 1'b1;
            fifo_we_o   = 1'b1;
            fifo_data_o = words[gidx];
            if (src_last_i[gidx]) state_next = ST_TRAILER;
          end
        end
        ST_TRAILER: begin
          if (!fifo_full_i) begin
            trl_wr      = 1'b1;
            fifo_we_o   = 1'b1;
            fifo_data_o = W'(make_trailer(4'(gidx), ovf, cnt));
            state_next  = ST_IDLE;
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  // Grant owner, round-robin pointer, word counter and sticky overflow.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      gidx       <= '0;
      last_grant <= LW'(NSRC - 1);
      cnt        <= '0;
      ovf        <= 1'b0;
    end else begin
      if (state == ST_IDLE && pick_any) gidx <= pick_idx;
      if (xfer) begin
        cnt <= cnt + CNT_W'(1);
        if (cnt == '1) ovf <= 1'b1;
      end
      if (trl_wr) begin
        cnt        <= '0;
        ovf        <= 1'b0;
        last_grant <= gidx;
      end
    end
  end

endmodule

// File: tb/tb_bus_fifo_arb.sv
// Self-checking bench for bus_fifo_arb against a packet-level reference model.
module tb_bus_fifo_arb;

  localparam int unsigned NSRC = 4;
  localparam int unsigned W    = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic [NSRC*W-1:0] src_data;
  logic [NSRC-1:0]   src_valid;
  logic [NSRC-1:0]   src_last;
  logic [NSRC-1:0]   src_ready;
  logic [W-1:0]      fifo_data;
  logic              fifo_we;
  logic              fifo_full;
  logic [NSRC-1:0]   grant;
  logic              busy;

  always #5 clk = ~clk;

  bus_fifo_arb #(.NSRC(NSRC), .W(W)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .src_data_i  (src_data),
    .src_valid_i (src_valid),
    .src_last_i  (src_last),
    .src_ready_o (src_ready),
    .fifo_data_o (fifo_data),
    .fifo_we_o   (fifo_we),
    .fifo_full_i (fifo_full),
    .grant_o     (grant),
    .busy_o      (busy)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Stimulus: per-source packet queues of {last, word}; log of DUT FIFO writes.
  logic [32:0] src_q [NSRC][$];
  logic [31:0] log_q [$];
  logic [31:0] exp_q [$];
  int          scen;
  int          cyc;
  int          busy_cnt;

  // Reference model: owner (-1 = idle), trailer pending, rr pointer, word count.
  int m_owner = -1;
  bit m_trl   = 1'b0;
  int m_last  = NSRC - 1;
  int m_cnt   = 0;
  bit m_ovf   = 1'b0;
  int trl_wait = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit pending();
    for (int k = 0; k < NSRC; k++) if (src_q[k].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit en_of(input int k);
    case (scen)
      2:       return (k == 0) ? (cyc >= 2) : (k == 2) ? !(cyc >= 3 && cyc < 6) : 1'b1;
      5:       return ($urandom_range(0, 3) != 0);
      default: return 1'b1;
    endcase
  endfunction

  function automatic bit full_of();
    case (scen)
      3:       return (cyc >= 3 && cyc < 8) || (m_trl && trl_wait < 3);
      5:       return ($urandom_range(0, 3) == 0);
      default: return 1'b0;
    endcase
  endfunction

  // One clock: drive, check at negedge against the model, advance the model.
  task automatic cycle();
    logic [NSRC-1:0] e_grant;
    logic [NSRC-1:0] e_ready;
    logic            e_we;
    logic [31:0]     e_data;
    logic            e_busy;
    bit              xfer;
    logic [32:0]     w;
    int              kk;
    for (int k = 0; k < NSRC; k++) begin
      if (src_q[k].size() > 0) begin
        src_valid[k]          = en_of(k);
        src_last[k]           = src_q[k][0][32];
        src_data[k*W +: W]    = src_q[k][0][31:0];
      end else begin
        src_valid[k]          = 1'b0;
        src_last[k]           = 1'b0;
        src_data[k*W +: W]    = $urandom;
      end
    end
    fifo_full = full_of();
    @(negedge clk);
    e_grant = '0; e_ready = '0; e_we = 1'b0; e_data = '0; e_busy = 1'b0; xfer = 1'b0;
    if (!rst && m_owner >= 0) begin
      e_busy           = 1'b1;
      e_grant[m_owner] = 1'b1;
      if (!m_trl) begin
        if (!fifo_full) e_ready[m_owner] = 1'b1;
        xfer = src_valid[m_owner] && !fifo_full;
        if (xfer) begin
          e_we   = 1'b1;
          e_data = src_q[m_owner][0][31:0];
        end
      end else if (!fifo_full) begin
        e_we   = 1'b1;
        e_data = {4'hE, 4'(m_owner), 7'd0, m_ovf, 16'(m_cnt)};
      end
    end
    chk("grant", 32'(grant), 32'(e_grant));
    chk("ready", 32'(src_ready), 32'(e_ready));
    chk("we", 32'(fifo_we), 32'(e_we));
    chk("busy", 32'(busy), 32'(e_busy));
    chk("we_while_full", 32'(fifo_we & fifo_full), 32'd0);
    if (e_we || rst) chk("data", fifo_data, e_data);
    if (busy) busy_cnt++;
    if (fifo_we) log_q.push_back(fifo_data);
    if (rst) begin
      m_owner = -1; m_trl = 1'b0; m_cnt = 0; m_ovf = 1'b0; m_last = NSRC - 1;
      log_q.delete();
    end else if (m_owner < 0) begin
      for (int i = 1; i <= NSRC; i++) begin
        kk = (m_last + i) % NSRC;
        if (src_valid[kk]) begin
          m_owner = kk;
          break;
        end
      end
    end else if (!m_trl) begin
      if (xfer) begin
        w = src_q[m_owner].pop_front();
        m_cnt++;
        if (m_cnt == 65536) begin
          m_cnt = 0;
          m_ovf = 1'b1;
        end
        if (w[32]) begin
          m_trl    = 1'b1;
          trl_wait = 0;
        end
      end
    end else if (!fifo_full) begin
      m_last = m_owner; m_owner = -1; m_trl = 1'b0; m_cnt = 0; m_ovf = 1'b0;
    end else begin
      trl_wait++;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic run_drain(input int max_cyc);
    int n = 0;
    while ((pending() || m_owner >= 0) && n < max_cyc) begin
      cycle();
      n++;
    end
    chk("drain_timeout", 32'(pending() || m_owner >= 0), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    cyc = 0;
    busy_cnt = 0;
  endtask

  task automatic push_pkt(input int k, input logic [31:0] base, input int len);
    for (int i = 0; i < len; i++) src_q[k].push_back({(i == len - 1), base + 32'(i)});
  endtask

  task automatic chk_log(input string tag);
    chk({tag, "_len"}, 32'(log_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) chk(tag, log_q[i], exp_q[i]);
  endtask

  initial begin
    int tot;
    rst = 1'b1; src_valid = '0; src_last = '0; src_data = '0; fifo_full = 1'b0;
    scen = 0; cyc = 0; busy_cnt = 0;
    cycle();
    cycle();
    rst = 1'b0;
    cyc = 0; busy_cnt = 0;

    // Source 1 three-word packet.
    src_q[1].push_back({1'b0, 32'h11});
    src_q[1].push_back({1'b0, 32'h22});
    src_q[1].push_back({1'b1, 32'h33});
    run_drain(50);
    chk("s1_busy_cycles", 32'(busy_cnt), 32'd4);
    exp_q = '{32'h11, 32'h22, 32'h33, 32'hE1000003};
    chk_log("s1_log");

    // All sources with one-word packets: round-robin 0,1,2,3,0.
    do_reset();
    push_pkt(0, 32'hA0, 1); push_pkt(0, 32'hA4, 1);
    push_pkt(1, 32'hA1, 1); push_pkt(2, 32'hA2, 1); push_pkt(3, 32'hA3, 1);
    run_drain(100);
    exp_q = '{32'hA0, 32'hE0000001, 32'hA1, 32'hE1000001, 32'hA2, 32'hE2000001,
              32'hA3, 32'hE3000001, 32'hA4, 32'hE0000001};
    chk_log("rr_log");

    // Back-pressure mid-packet and during trailer.
    do_reset();
    scen = 3;
    push_pkt(3, 32'h300, 6);
    run_drain(100);
    exp_q = '{32'h300, 32'h301, 32'h302, 32'h303, 32'h304, 32'h305, 32'hE3000006};
    chk_log("full_log");

    // Source 2 stalls mid-packet while source 0 waits.
    do_reset();
    scen = 2;
    push_pkt(2, 32'h200, 5);
    push_pkt(0, 32'h100, 2);
    run_drain(100);
    exp_q = '{32'h200, 32'h201, 32'h202, 32'h203, 32'h204, 32'hE2000005,
              32'h100, 32'h101, 32'hE0000002};
    chk_log("stall_log");

    // Reset two words into a packet.
    do_reset();
    scen = 0;
    push_pkt(1, 32'h400, 5);
    cycle(); cycle(); cycle();
    chk("pre_rst_words", 32'(log_q.size()), 32'd2);
    src_q[1].delete();
    do_reset();
    push_pkt(0, 32'h500, 1);
    push_pkt(2, 32'h600, 1);
    cycle();
    chk("post_rst_grant", 32'(grant), 32'h1);
    run_drain(50);
    exp_q = '{32'h500, 32'hE0000001, 32'h600, 32'hE2000001};
    chk_log("rst_log");

    // Randomized traffic with random gaps and back-pressure.
    do_reset();
    scen = 5;
    tot = 0;
    for (int k = 0; k < NSRC; k++) begin
      int np;
      np = $urandom_range(1, 3);
      for (int p = 0; p < np; p++) begin
        int len;
        len = $urandom_range(1, 6);
        push_pkt(k, $urandom, len);
        tot += len + 1;
      end
    end
    run_drain(3000);
    chk("rand_total", 32'(log_q.size()), 32'(tot));

    // Counter wrap: 65537-word packet.
    do_reset();
    scen = 0;
    push_pkt(0, 32'h0, 65537);
    run_drain(70000);
    chk("wrap_len", 32'(log_q.size()), 32'd65538);
    if (log_q.size() > 0) chk("wrap_trailer", log_q[log_q.size() - 1], 32'hE0010001);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
